jtag_emu_ctrl: RTL and testbench
================================

// Module: jtag_emu_ctrl
// PURPOSE
//  Bit-banging JTAG shift engine for the PS7-emulated debug path of the FPGA top.
//  The PS posts a shift command: length, TMS vector and TDI vector.
//  The block generates TCK/TMS/TDI/TRSTn toward the PULPino TAP and captures TDO.
//  It returns the captured TDO vector through a valid/ready response port.
//  It replaces per-edge software toggling of the jtag_emu GPIO word.
// PARAMETERS
//  CLK_DIV   4   clk cycles per TCK half-period; legal range 1..255
//  MAX_LEN   32  maximum bits per command; sets vector widths
// PORTS
//  clk          in   1        system clock (ps7_clk domain)
//  rst_n        in   1        synchronous, active-low reset
//  cmd_valid_i  in   1        command present
//  cmd_ready_o  out  1        command accepted when valid&ready
//  cmd_len_i    in   6        number of TCK cycles, 0..63
//  cmd_tms_i    in   MAX_LEN  TMS bit per TCK cycle, LSB first
//  cmd_tdi_i    in   MAX_LEN  TDI bit per TCK cycle, LSB first
//  trst_req_i   in   1        request TRSTn pulse; sampled only in IDLE
//  rsp_valid_o  out  1        captured TDO vector available
//  rsp_ready_i  in   1        response consumed when valid&ready
//  rsp_tdo_o    out  MAX_LEN  captured TDO, LSB = first bit; unshifted bits are 0
//  busy_o       out  1        high in any state other than IDLE
//  tck_o        out  1        JTAG TCK
//  tms_o        out  1        JTAG TMS
//  tdi_o        out  1        JTAG TDI
//  trstn_o      out  1        JTAG TRSTn, active low
//  tdo_i        in   1        JTAG TDO from TAP
// BEHAVIOUR
//  Reset values (sync, rst_n=0 at a clk edge):
//   - tck_o=0, tms_o=1, tdi_o=0, trstn_o=0 (TAP held in reset).
//   - cmd_ready_o=0, rsp_valid_o=0, rsp_tdo_o=0, busy_o=0, state=IDLE.
//   - trstn_o goes to 1 on the first clk edge after rst_n=1.
//  FSM states: IDLE, TRST, SHIFT_LO, SHIFT_HI, RESP. All outputs are registered.
//  IDLE:
//   - cmd_ready_o=1, tck_o=0.
//   - trst_req_i has priority over cmd_valid_i in the same cycle: go to TRST; cmd not accepted.
//   - On valid&ready: latch len=min(cmd_len_i,MAX_LEN), latch tms/tdi vectors; bit index i=0.
//     - len=0: go straight to RESP with rsp_tdo_o=0; no TCK edge.
//     - otherwise: go to SHIFT_LO.
//  TRST:
//   - trstn_o=0, tms_o=1, tck_o=0 for 2*CLK_DIV cycles.
//   - then trstn_o=1 and return to IDLE; no response generated.
//  SHIFT_LO:
//   - tms_o=tms[i] and tdi_o=tdi[i] from the first cycle; tck_o=0; duration CLK_DIV cycles.
//  SHIFT_HI:
//   - tck_o=1 for CLK_DIV cycles.
//   - tdo_i is sampled into rsp_tdo[i] at the edge that enters SHIFT_HI (TCK rising).
//   - on exit: i=i+1; if i==len go to RESP, else go to SHIFT_LO.
//  Timing: accept at cycle t. First low phase starts at t+1. rsp_valid_o=1 at t+1+len*2*CLK_DIV.
//  RESP:
//   - rsp_valid_o=1; rsp_tdo_o stable until rsp_valid&rsp_ready, then IDLE next cycle.
//   - tck_o=0; tms_o/tdi_o hold the last driven values.
//  cmd_ready_o=0 in every state except IDLE, so a new command is never accepted while a response is pending.
//  Half-period counter is 8 bits and reloads on every phase change; no drift over long commands.
//  rst_n low mid-shift or mid-RESP:
//   - abort immediately to reset values; pending response discarded; no partial TCK pulse extended.
//  trst_req_i asserted outside IDLE is ignored (level must be held until IDLE to take effect).
// TESTING
//  - Reset, then idle: trstn_o=0 during reset, 1 one cycle after release; tck_o=0, tms_o=1, cmd_ready_o=1.
//  - CLK_DIV=4, len=5, tms=5'b11111, tdo_i=1:
//    - exactly 5 TCK pulses, each 4 cycles high / 4 low;
//    - rsp_valid at t+41, rsp_tdo=32'h1F.
//  - len=32, tdi=32'hA5A5_0F0F, TDO model returns TDI delayed by one TCK:
//    - rsp_tdo=32'h4B4A_1E1E (bit0 = model reset value 0).
//  - len=0 -> rsp_valid at t+1, rsp_tdo=0, no tck_o edge; len=40 -> clamped, exactly 32 pulses.
//  - trst_req_i and cmd_valid_i both high in IDLE -> TRST first (trstn_o low 8 cycles), cmd accepted afterward.
//  - rsp_ready_i held low 20 cycles -> rsp_valid/tdo stable, cmd_ready_o=0; rst_n pulsed mid-shift -> reset values next edge.

Source files
------------

// File: rtl/jtag_emu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jtag_emu_ctrl
// Purpose  : Bit-banging JTAG shift engine. It takes a length/TMS/TDI command,
//            drives TCK/TMS/TDI/TRSTn and returns the TDO bits it captured.
// Revision : 1.0  initial release
// ============================================================================
module jtag_emu_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [5:0]         cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_tms_i,
    input  logic [MAX_LEN-1:0] cmd_tdi_i,
    input  logic               trst_req_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_tdo_o,
    output logic               busy_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    output logic               trstn_o,
    input  logic               tdo_i
);

    localparam logic [7:0] c_div_m1  = 8'(CLK_DIV - 1);
    localparam logic [5:0] c_len_max = 6'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TRST     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_RESP     = 3'd4
    } state_e;

    state_e             state_q;
    logic [7:0]         cnt_q;
    logic               trst_half_q;
    logic [5:0]         rem_q;
    logic [MAX_LEN-1:0] mask_q;
    logic [MAX_LEN-1:0] tms_sh_q;
    logic [MAX_LEN-1:0] tdi_sh_q;
    logic [MAX_LEN-1:0] tdo_q;
    logic               tck_q;
    logic               tms_q;
    logic               tdi_q;
    logic               trstn_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic               busy_q;

    logic [5:0]         len_d;

    assign len_d = (cmd_len_i > c_len_max) ? c_len_max : cmd_len_i;

    // Bit 0 of each vector is driven on accept; the shifters hold the remaining bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            trst_half_q <= 1'b0;
            rem_q       <= 6'd0;
            mask_q      <= '0;
            tms_sh_q    <= '0;
            tdi_sh_q    <= '0;
            tdo_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trstn_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    tck_q <= 1'b0;
                    if (trst_req_i) begin
                        state_q     <= S_TRST;
                        trstn_q     <= 1'b0;
                        tms_q       <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= c_div_m1;
                        trst_half_q <= 1'b0;
                    end else if (cmd_valid_i && cmd_ready_q) begin
                        trstn_q     <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        tdo_q       <= '0;
                        mask_q      <= {{(MAX_LEN-1){1'b0}}, 1'b1};
                        rem_q       <= len_d;
                        tms_sh_q    <= cmd_tms_i >> 1;
                        tdi_sh_q    <= cmd_tdi_i >> 1;
                        if (len_d == 6'd0) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT_LO;
                            tms_q   <= cmd_tms_i[0];
                            tdi_q   <= cmd_tdi_i[0];
                            cnt_q   <= c_div_m1;
                        end
                    end else begin
                        trstn_q     <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                S_TRST: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (!trst_half_q) begin
                        trst_half_q <= 1'b1;
                        cnt_q       <= c_div_m1;
                    end else begin
                        state_q     <= S_IDLE;
                        trstn_q     <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                S_SHIFT_LO: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        state_q <= S_SHIFT_HI;
                        tck_q   <= 1'b1;
                        cnt_q   <= c_div_m1;
                        if (tdo_i) begin
                            tdo_q <= tdo_q | mask_q;
                        end
                    end
                end

                S_SHIFT_HI: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        tck_q  <= 1'b0;
                        mask_q <= mask_q << 1;
                        rem_q  <= rem_q - 6'd1;
                        if (rem_q == 6'd1) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q  <= S_SHIFT_LO;
                            tms_q    <= tms_sh_q[0];
                            tdi_q    <= tdi_sh_q[0];
                            tms_sh_q <= tms_sh_q >> 1;
                            tdi_sh_q <= tdi_sh_q >> 1;
                            cnt_q    <= c_div_m1;
                        end
                    end
                end

                S_RESP: begin
                    tck_q <= 1'b0;
                    if (rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_tdo_o   = tdo_q;
    assign busy_o      = busy_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;
    assign trstn_o     = trstn_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_emu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_emu_ctrl
// Purpose  : Directed self-checking bench for jtag_emu_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_jtag_emu_ctrl;

    localparam int CLK_DIV = 4;
    localparam int MAX_LEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [5:0]  cmd_len_i;
    logic [31:0] cmd_tms_i;
    logic [31:0] cmd_tdi_i;
    logic        trst_req_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_tdo_o;
    logic        busy_o;
    logic        tck_o;
    logic        tms_o;
    logic        tdi_o;
    logic        trstn_o;
    logic        tdo_i;

    logic        tdo_sel;
    logic        tdo_const;
    logic        tdo_clr;
    logic        tdo_dly;

    int n_assert = 0;
    int n_fail   = 0;
    int tck_rises = 0;

    always #5 clk = ~clk;

    jtag_emu_ctrl #(
        .CLK_DIV (CLK_DIV),
        .MAX_LEN (MAX_LEN)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_len_i   (cmd_len_i),
        .cmd_tms_i   (cmd_tms_i),
        .cmd_tdi_i   (cmd_tdi_i),
        .trst_req_i  (trst_req_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_tdo_o   (rsp_tdo_o),
        .busy_o      (busy_o),
        .tck_o       (tck_o),
        .tms_o       (tms_o),
        .tdi_o       (tdi_o),
        .trstn_o     (trstn_o),
        .tdo_i       (tdo_i)
    );

    // TAP model: TDO returns TDI delayed by one TCK rising edge.
    always @(posedge tck_o or posedge tdo_clr) begin
        if (tdo_clr) tdo_dly <= 1'b0;
        else         tdo_dly <= tdi_o;
    end

    always @(posedge tck_o) tck_rises++;

    assign tdo_i = tdo_sel ? tdo_dly : tdo_const;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [5:0] len, input logic [31:0] tms, input logic [31:0] tdi);
        cmd_valid_i = 1'b1;
        cmd_len_i   = len;
        cmd_tms_i   = tms;
        cmd_tdi_i   = tdi;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    // Walks cycle by cycle from the accept edge, checking TCK shape and TMS/TDI bits.
    task automatic wait_rsp(input int nbits, input logic [31:0] tms, input logic [31:0] tdi,
                            output int lat, output int werr);
        int  b;
        logic exp_tck;
        lat  = -1;
        werr = 0;
        for (int j = 0; j < 2000; j++) begin
            if (rsp_valid_o === 1'b1) begin
                lat = j;
                break;
            end
            if (j < nbits * 2 * CLK_DIV) begin
                exp_tck = ((j / CLK_DIV) % 2) == 1;
                b       = j / (2 * CLK_DIV);
                if (tck_o !== exp_tck || tms_o !== tms[b] || tdi_o !== tdi[b]) werr++;
            end else begin
                werr++;
            end
            tick();
        end
    endtask

    task automatic consume(input string tag);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk({tag, "_rsp_valid_clr"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_cmd_ready_back"}, 32'(cmd_ready_o), 32'd1);
        chk({tag, "_busy_clr"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int werr;
        int p0;
        int low;
        int serr;

        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_len_i   = 6'd0;
        cmd_tms_i   = 32'd0;
        cmd_tdi_i   = 32'd0;
        trst_req_i  = 1'b0;
        rsp_ready_i = 1'b0;
        tdo_sel     = 1'b0;
        tdo_const   = 1'b1;
        tdo_clr     = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_tck",       32'(tck_o),       32'd0);
        chk("rst_tms",       32'(tms_o),       32'd1);
        chk("rst_tdi",       32'(tdi_o),       32'd0);
        chk("rst_trstn",     32'(trstn_o),     32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_tdo",   rsp_tdo_o,        32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_trstn",     32'(trstn_o),     32'd1);
        chk("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("idle_tck",       32'(tck_o),       32'd0);
        chk("idle_tms",       32'(tms_o),       32'd1);
        chk("idle_busy",      32'(busy_o),      32'd0);

        // len=5, TMS all ones, TDO tied high
        p0 = tck_rises;
        send_cmd(6'd5, 32'h1F, 32'h15);
        wait_rsp(5, 32'h1F, 32'h15, lat, werr);
        chk("len5_latency",   32'(lat),            32'd40);
        chk("len5_wave",      32'(werr),           32'd0);
        chk("len5_pulses",    32'(tck_rises - p0), 32'd5);
        chk("len5_tdo",       rsp_tdo_o,           32'h1F);
        chk("len5_cmd_ready", 32'(cmd_ready_o),    32'd0);
        chk("len5_busy",      32'(busy_o),         32'd1);
        chk("len5_tck_resp",  32'(tck_o),          32'd0);
        chk("len5_tdi_hold",  32'(tdi_o),          32'd1);
        consume("len5");

        // len=32, TDO = TDI delayed one TCK
        tdo_sel = 1'b1;
        tdo_clr = 1'b1;
        #1;
        tdo_clr = 1'b0;
        p0 = tck_rises;
        send_cmd(6'd32, 32'h0000_0000, 32'hA5A5_0F0F);
        wait_rsp(32, 32'h0000_0000, 32'hA5A5_0F0F, lat, werr);
        chk("len32_latency", 32'(lat),            32'd256);
        chk("len32_wave",    32'(werr),           32'd0);
        chk("len32_pulses",  32'(tck_rises - p0), 32'd32);
        chk("len32_tdo",     rsp_tdo_o,           32'h4B4A_1E1E);
        consume("len32");
        tdo_sel = 1'b0;

        // len=0: immediate response, no TCK
        p0 = tck_rises;
        send_cmd(6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rsp(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, werr);
        chk("len0_latency", 32'(lat),            32'd0);
        chk("len0_tdo",     rsp_tdo_o,           32'd0);
        chk("len0_pulses",  32'(tck_rises - p0), 32'd0);
        chk("len0_tck",     32'(tck_o),          32'd0);
        consume("len0");

        // len=40 clamps to 32
        p0 = tck_rises;
        send_cmd(6'd40, 32'hFFFF_0000, 32'h1234_5678);
        wait_rsp(32, 32'hFFFF_0000, 32'h1234_5678, lat, werr);
        chk("len40_latency", 32'(lat),            32'd256);
        chk("len40_wave",    32'(werr),           32'd0);
        chk("len40_pulses",  32'(tck_rises - p0), 32'd32);
        chk("len40_tdo",     rsp_tdo_o,           32'hFFFF_FFFF);
        consume("len40");

        // TRST wins over a simultaneous command, which is accepted afterward
        trst_req_i  = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_len_i   = 6'd3;
        cmd_tms_i   = 32'h5;
        cmd_tdi_i   = 32'h6;
        tick();
        trst_req_i = 1'b0;
        chk("trst_trstn",     32'(trstn_o),     32'd0);
        chk("trst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("trst_tms",       32'(tms_o),       32'd1);
        chk("trst_busy",      32'(busy_o),      32'd1);
        low = 0;
        for (int j = 0; j < 50; j++) begin
            if (trstn_o === 1'b1) break;
            low++;
            tick();
        end
        chk("trst_low_cycles",  32'(low),         32'd8);
        chk("trst_ready_after", 32'(cmd_ready_o), 32'd1);
        chk("trst_rsp_none",    32'(rsp_valid_o), 32'd0);
        p0 = tck_rises;
        tick();
        cmd_valid_i = 1'b0;
        wait_rsp(3, 32'h5, 32'h6, lat, werr);
        chk("post_trst_latency", 32'(lat),            32'd24);
        chk("post_trst_wave",    32'(werr),           32'd0);
        chk("post_trst_pulses",  32'(tck_rises - p0), 32'd3);
        chk("post_trst_tdo",     rsp_tdo_o,           32'h7);

        // Response held pending for 20 cycles
        serr = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (rsp_valid_o !== 1'b1 || rsp_tdo_o !== 32'h7 || cmd_ready_o !== 1'b0) serr++;
        end
        chk("stall_stable", 32'(serr),        32'd0);
        chk("stall_valid",  32'(rsp_valid_o), 32'd1);
        consume("stall");

        // TRST request mid-shift is ignored; reset mid-shift aborts
        send_cmd(6'd8, 32'h0, 32'hFF);
        trst_req_i = 1'b1;
        repeat (5) tick();
        chk("mid_tck_high",    32'(tck_o),   32'd1);
        chk("mid_trst_ignore", 32'(trstn_o), 32'd1);
        trst_req_i = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("abort_tck",       32'(tck_o),       32'd0);
        chk("abort_tms",       32'(tms_o),       32'd1);
        chk("abort_tdi",       32'(tdi_o),       32'd0);
        chk("abort_trstn",     32'(trstn_o),     32'd0);
        chk("abort_busy",      32'(busy_o),      32'd0);
        chk("abort_rsp_tdo",   rsp_tdo_o,        32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready_o), 32'd0);
        rst_n = 1'b1;
        p0 = tck_rises;
        tick();
        chk("rerun_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rerun_trstn",     32'(trstn_o),     32'd1);
        repeat (10) tick();
        chk("rerun_no_pulses", 32'(tck_rises - p0), 32'd0);
        chk("rerun_no_rsp",    32'(rsp_valid_o),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
